tsoip_rx_deframer: RTL

- Receive-side counterpart of the TSoIP transmit chain.
- Takes the byte stream recovered from the PHY side of an Ethernet port: one byte per clock, starting at MAC destination byte 0, ending at the last FCS byte.
- Validates the Ethernet/IPv4/UDP header against the local configuration, strips the 42-byte header and the 4-byte FCS, and emits N TS packets of fixed length with per-packet sync.
- Frames that fail header matching are discarded and counted. The FCS verdict arrives from an external CRC checker and is reported per frame.

---
 rtl/tsoip_rx_deframer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tsoip_rx_deframer.sv
// TSoIP receive deframer: checks the Ethernet/IPv4/UDP header of each frame,
// strips header and FCS, and emits fixed-length TS packets with per-packet sync.
module tsoip_rx_deframer #(
  parameter int unsigned HDR_LEN = 42,
  parameter int unsigned FCS_LEN = 4
) (
  input  logic        i_Clk,
  input  logic        i_nRst,
  input  logic        i_Valid,
  input  logic        i_Sync,
  input  logic        i_End,
  input  logic [7:0]  i_Data,
  input  logic        i_CrcOk,
  input  logic [47:0] i_MacLocal,
  input  logic [31:0] i_IpLocal,
  input  logic [15:0] i_PortDest,
  input  logic [7:0]  i_PacketLength,
  input  logic [2:0]  i_NumberPacket,
  output logic        o_Valid,
  output logic        o_Sync,
  output logic [7:0]  o_Data,
  output logic        o_Abort,
  output logic        o_FrameOk,
  output logic        o_FrameErr,
  output logic [15:0] o_DropCnt
);

  typedef enum logic [2:0] {IDLE, HDR, PAY, TRAIL, DROP} state_t;

  state_t      state, stateNext;
  logic [10:0] bcnt, bcntNext;
  logic [7:0]  pcnt, pcntNext;
  logic [7:0]  pktLen, pktLenNext;
  logic [2:0]  numPkt, numPktNext;
  logic        macBad, macBadNext, bcBad, bcBadNext, othBad, othBadNext;
  logic [10:0] payLen;
  logic [5:0]  hOff;
  logic        macMis, bcMis, othMis;
  logic        validNext, syncNext, abortNext, okNext, errNext, dropInc;
  logic [7:0]  dataNext;

  assign payLen = {3'b000, pktLen} * {8'h00, numPkt};

  // A new i_Sync byte is always header offset 0, whatever state we were in.
  assign hOff = (state == HDR && !i_Sync) ? bcnt[5:0] : '0;

  // MAC bytes track two alternatives (local, broadcast); a frame is bad only if both miss.
  always_comb begin
    macMis = 1'b0;
    bcMis  = 1'b0;
    othMis = 1'b0;
    case (hOff)
      6'd0:  begin macMis = i_Data != i_MacLocal[47:40]; bcMis = i_Data != 8'hFF; end
      6'd1:  begin macMis = i_Data != i_MacLocal[39:32]; bcMis = i_Data != 8'hFF; end
      6'd2:  begin macMis = i_Data != i_MacLocal[31:24]; bcMis = i_Data != 8'hFF; end
      6'd3:  begin macMis = i_Data != i_MacLocal[23:16]; bcMis = i_Data != 8'hFF; end
      6'd4:  begin macMis = i_Data != i_MacLocal[15:8];  bcMis = i_Data != 8'hFF; end
      6'd5:  begin macMis = i_Data != i_MacLocal[7:0];   bcMis = i_Data != 8'hFF; end
      6'd12: othMis = i_Data != 8'h08;
      6'd13: othMis = i_Data != 8'h00;
      6'd14: othMis = i_Data != 8'h45;
      6'd23: othMis = i_Data != 8'h11;
      6'd30: othMis = i_Data != i_IpLocal[31:24];
      6'd31: othMis = i_Data != i_IpLocal[23:16];
      6'd32: othMis = i_Data != i_IpLocal[15:8];
      6'd33: othMis = i_Data != i_IpLocal[7:0];
      6'd36: othMis = i_Data != i_PortDest[15:8];
      6'd37: othMis = i_Data != i_PortDest[7:0];
      default: ;
    endcase
  end

  always_comb begin
    stateNext  = state;
    bcntNext   = bcnt;
    pcntNext   = pcnt;
    pktLenNext = pktLen;
    numPktNext = numPkt;
    macBadNext = macBad;
    bcBadNext  = bcBad;
    othBadNext = othBad;
    validNext  = 1'b0;
    syncNext   = 1'b0;
    dataNext   = '0;
    abortNext  = 1'b0;
    okNext     = 1'b0;
    errNext    = 1'b0;
    dropInc    = 1'b0;
    if (i_Valid) begin
      if (i_Sync) begin
        if (state == PAY) begin
          errNext   = 1'b1;
          abortNext = pcnt != '0;
        end
        pktLenNext = i_PacketLength;
        numPktNext = i_NumberPacket;
        macBadNext = macMis;
        bcBadNext  = bcMis;
        othBadNext = othMis;
        bcntNext   = 11'd1;
        pcntNext   = '0;
        if (i_End) begin
          dropInc   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = HDR;
        end
      end else begin
        case (state)
          HDR: begin
            macBadNext = macBad | macMis;
            bcBadNext  = bcBad | bcMis;
            othBadNext = othBad | othMis;
            bcntNext   = bcnt + 11'd1;
            if (i_End) begin
              dropInc   = 1'b1;
              stateNext = IDLE;
            end else if (bcnt == 11'(HDR_LEN - 1)) begin
              bcntNext = '0;
              pcntNext = '0;
              if (((macBad | macMis) & (bcBad | bcMis)) | othBad | othMis) begin
                dropInc   = 1'b1;
                stateNext = DROP;
              end else begin
                stateNext = PAY;
              end
            end
          end
          PAY: begin
            if (i_End) begin
              errNext   = 1'b1;
              abortNext = pcnt != '0;
              stateNext = IDLE;
            end else begin
              validNext = 1'b1;
              dataNext  = i_Data;
              syncNext  = pcnt == '0;
              pcntNext  = (pcnt == pktLen - 8'd1) ? '0 : pcnt + 8'd1;
              bcntNext  = bcnt + 11'd1;
              if (bcnt == payLen - 11'd1) begin
                bcntNext  = '0;
                stateNext = TRAIL;
              end
            end
          end
          TRAIL: begin
            if (bcnt != '1) bcntNext = bcnt + 11'd1;
            if (i_End) begin
              okNext    = (bcnt == 11'(FCS_LEN - 1)) && i_CrcOk;
              errNext   = !okNext;
              stateNext = IDLE;
            end
          end
          DROP: if (i_End) stateNext = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state      <= IDLE;
      bcnt       <= '0;
      pcnt       <= '0;
      pktLen     <= '0;
      numPkt     <= '0;
      macBad     <= 1'b0;
      bcBad      <= 1'b0;
      othBad     <= 1'b0;
      o_Valid    <= 1'b0;
      o_Sync     <= 1'b0;
      o_Data     <= '0;
      o_Abort    <= 1'b0;
      o_FrameOk  <= 1'b0;
      o_FrameErr <= 1'b0;
      o_DropCnt  <= '0;
    end else begin
      state      <= stateNext;
      bcnt       <= bcntNext;
      pcnt       <= pcntNext;
      pktLen     <= pktLenNext;
      numPkt     <= numPktNext;
      macBad     <= macBadNext;
      bcBad      <= bcBadNext;
      othBad     <= othBadNext;
      o_Valid    <= validNext;
      o_Sync     <= syncNext;
      o_Data     <= dataNext;
      o_Abort    <= abortNext;
      o_FrameOk  <= okNext;
      o_FrameErr <= errNext;
      if (dropInc && o_DropCnt != '1) o_DropCnt <= o_DropCnt + 16'd1;
    end
  end

endmodule
